// File: rtl/sa_result_drain.sv
// sa_result_drain: snapshots one output row of the systolic array core,
// acknowledges it with a single-cycle outread pulse, then serializes the
// valid columns of that row onto a ready/valid stream in ascending order.
// Optional build macro SA_DRAIN_ROWCNT_EN adds a 16-bit wrapping row_count
// output that counts every capture, including flush captures.
module sa_result_drain #(
   parameter int ROWS     = 8,
   parameter int OUTWIDTH = 32
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic [OUTWIDTH-1:0]       routport [0:ROWS-1],
   input  logic [0:ROWS-1]           rvalidport,
   output logic                      outread,
   input  logic                      flush,
   output logic [OUTWIDTH-1:0]       m_data,
   output logic [$clog2(ROWS)-1:0]   m_col,
   output logic                      m_last,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic                      busy
`ifdef SA_DRAIN_ROWCNT_EN
   ,output logic [15:0]              row_count
`endif
);

   localparam int CW = $clog2(ROWS);

   typedef enum logic {IDLE, SEND} state_t;

   state_t              state;
   logic [OUTWIDTH-1:0] snap [0:ROWS-1];
   logic [0:ROWS-1]     mask;

   logic                capture;
   logic [CW-1:0]       first_col;
   logic [0:ROWS-1]     rem_mask;
   logic [CW-1:0]       next_col;

   // Index of the lowest-numbered set bit; zero when the mask is empty.
   function automatic logic [CW-1:0] low_idx(input logic [0:ROWS-1] m);
      low_idx = '0;
      for (int i = ROWS-1; i >= 0; i--) begin
         if (m[i]) low_idx = CW'(i);
      end
   endfunction

   // Copy of the mask with one column removed.
   function automatic logic [0:ROWS-1] clear_bit(input logic [0:ROWS-1] m,
                                                 input logic [CW-1:0]  idx);
      clear_bit      = m;
      clear_bit[idx] = 1'b0;
   endfunction

   // Capture decision and next-column lookahead so every output can be registered.
   always_comb begin
      capture   = (state == IDLE) &&
                  ((&rvalidport) || (flush && (|rvalidport)));
      first_col = low_idx(rvalidport);
      rem_mask  = clear_bit(mask, m_col);
      next_col  = low_idx(rem_mask);
   end

   // Row FSM: snapshot on capture, then walk the remaining mask one beat per handshake.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state   <= IDLE;
         snap    <= '{default: '0};
         mask    <= '0;
         outread <= 1'b0;
         m_valid <= 1'b0;
         m_last  <= 1'b0;
         m_data  <= '0;
         m_col   <= '0;
         busy    <= 1'b0;
      end else begin
         outread <= 1'b0;
         case (state)
            IDLE: begin
               if (capture) begin
                  snap    <= routport;
                  mask    <= rvalidport;
                  m_col   <= first_col;
                  m_data  <= routport[first_col];
                  m_last  <= (clear_bit(rvalidport, first_col) == '0);
                  m_valid <= 1'b1;
                  busy    <= 1'b1;
                  outread <= 1'b1;
                  state   <= SEND;
               end
            end
            SEND: begin
               if (m_valid && m_ready) begin
                  if (m_last) begin
                     mask    <= '0;
                     m_valid <= 1'b0;
                     m_last  <= 1'b0;
                     busy    <= 1'b0;
                     state   <= IDLE;
                  end else begin
                     mask   <= rem_mask;
                     m_col  <= next_col;
                     m_data <= snap[next_col];
                     m_last <= (clear_bit(rem_mask, next_col) == '0);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SA_DRAIN_ROWCNT_EN
   // Count captured rows; wraps naturally at 16 bits.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) row_count <= '0;
      else if (capture) row_count <= row_count + 16'd1;
   end
`endif

endmodule

// File: tb/tb_sa_result_drain.sv
// Scoreboard bench for sa_result_drain: expected beats are queued when a row is
// driven and popped as the stream hands them off. Set SA_DRAIN_ROWCNT_EN to
// also exercise the row counter.
module tb_sa_result_drain;

   localparam int ROWS = 8;
   localparam int OW   = 32;
   localparam int CW   = $clog2(ROWS);

   typedef struct packed {
      logic [CW-1:0] col;
      logic [OW-1:0] data;
      logic          last;
   } beat_t;

   logic            clk = 1'b0;
   logic            rstn;
   logic [OW-1:0]   routport [0:ROWS-1];
   logic [0:ROWS-1] rvalidport;
   logic            outread;
   logic            flush;
   logic [OW-1:0]   m_data;
   logic [CW-1:0]   m_col;
   logic            m_last;
   logic            m_valid;
   logic            m_ready;
   logic            busy;
`ifdef SA_DRAIN_ROWCNT_EN
   logic [15:0]     row_count;
`endif

   beat_t q[$];
   int    total = 0;
   int    bad   = 0;

   sa_result_drain #(.ROWS(ROWS), .OUTWIDTH(OW)) dut (
      .clk(clk), .rstn(rstn), .routport(routport), .rvalidport(rvalidport),
      .outread(outread), .flush(flush), .m_data(m_data), .m_col(m_col),
      .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready), .busy(busy)
`ifdef SA_DRAIN_ROWCNT_EN
      , .row_count(row_count)
`endif
   );

   always #5 clk = ~clk;

   // Drive one row (inputs only) and queue the beats it should produce.
   task automatic load_row(input logic [0:ROWS-1] vm, input logic fl, input bit rnd);
      int    hi;
      beat_t e;
      hi = 0;
      for (int i = 0; i < ROWS; i++) begin
         routport[i] = rnd ? OW'($urandom) : OW'(i * 16);
         if (vm[i]) hi = i;
      end
      for (int i = 0; i < ROWS; i++) begin
         if (vm[i]) begin
            e.col  = CW'(i);
            e.data = routport[i];
            e.last = (i == hi);
            q.push_back(e);
         end
      end
      rvalidport = vm;
      flush      = fl;
   endtask

   task automatic test_reset;
      rstn = 1'b0; flush = 1'b0; m_ready = 1'b0; rvalidport = '0;
      for (int i = 0; i < ROWS; i++) routport[i] = '0;
      repeat (2) @(negedge clk);
      total++;
      if ({outread, m_valid, m_last, busy} !== 4'b0000) begin
         bad++;
         $display("FAIL reset_ctrl got=%b want=0000", {outread, m_valid, m_last, busy});
      end
      total++;
      if (m_data !== '0 || m_col !== '0) begin
         bad++;
         $display("FAIL reset_data got data=%h col=%0d want 0/0", m_data, m_col);
      end
`ifdef SA_DRAIN_ROWCNT_EN
      total++;
      if (row_count !== 16'd0) begin
         bad++;
         $display("FAIL reset_rowcnt got=%0d want=0", row_count);
      end
`endif
      rstn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_full_row;
      beat_t e;
      int    pulses;
      @(negedge clk);
      load_row('1, 1'b0, 1'b0);
      m_ready = 1'b1;
      @(negedge clk);
      rvalidport = '0;
      total++;
      if (outread !== 1'b1 || busy !== 1'b1) begin
         bad++;
         $display("FAIL full_first_cycle got outread=%b busy=%b want 1/1", outread, busy);
      end
      pulses = 0;
      for (int c = 0; c < ROWS; c++) begin
         if (outread) pulses++;
         total++;
         if (m_valid !== 1'b1 || q.size() == 0) begin
            bad++;
            $display("FAIL full_valid beat=%0d got valid=%b want 1 (queued=%0d)", c, m_valid, q.size());
         end else begin
            e = q.pop_front();
            if ({m_col, m_data, m_last} !== {e.col, e.data, e.last}) begin
               bad++;
               $display("FAIL full_beat got col=%0d data=%h last=%b want col=%0d data=%h last=%b",
                        m_col, m_data, m_last, e.col, e.data, e.last);
            end
         end
         @(negedge clk);
      end
      total++;
      if (pulses != 1 || busy !== 1'b0 || m_valid !== 1'b0) begin
         bad++;
         $display("FAIL full_end got pulses=%0d busy=%b valid=%b want 1/0/0", pulses, busy, m_valid);
      end
   endtask

   task automatic test_backpressure;
      beat_t              e;
      int                 pulses;
      bit                 have_prev;
      logic [CW+OW:0]     prev;
      @(negedge clk);
      load_row('1, 1'b0, 1'b1);
      @(negedge clk);
      rvalidport = '0;
      pulses = 0; have_prev = 0; prev = '0;
      for (int c = 0; c < 40; c++) begin
         if (!m_valid) break;
         if (outread) pulses++;
         m_ready = (c % 3 == 0);
         if (have_prev) begin
            total++;
            if ({m_col, m_data, m_last} !== prev) begin
               bad++;
               $display("FAIL bp_hold got=%h want=%h", {m_col, m_data, m_last}, prev);
            end
         end
         if (m_ready) begin
            total++;
            if (q.size() == 0) begin
               bad++;
               $display("FAIL bp_extra got col=%0d want no beat", m_col);
            end else begin
               e = q.pop_front();
               if ({m_col, m_data, m_last} !== {e.col, e.data, e.last}) begin
                  bad++;
                  $display("FAIL bp_beat got col=%0d data=%h last=%b want col=%0d data=%h last=%b",
                           m_col, m_data, m_last, e.col, e.data, e.last);
               end
            end
         end
         have_prev = !m_ready;
         prev      = {m_col, m_data, m_last};
         @(negedge clk);
      end
      m_ready = 1'b1;
      total++;
      if (q.size() != 0 || pulses != 1 || m_valid !== 1'b0) begin
         bad++;
         $display("FAIL bp_end got left=%0d pulses=%0d valid=%b want 0/1/0", q.size(), pulses, m_valid);
      end
   endtask

   task automatic test_flush_partial;
      beat_t e;
      int    pulses, beats;
      logic [0:ROWS-1] pm;
      pm = 8'b0010_0100;
      @(negedge clk);
      load_row(pm, 1'b1, 1'b1);
      m_ready = 1'b1;
      @(negedge clk);
      rvalidport = '0; flush = 1'b0;
      pulses = 0; beats = 0;
      for (int c = 0; c < 10; c++) begin
         if (outread) pulses++;
         if (m_valid) begin
            beats++;
            total++;
            if (q.size() == 0) begin
               bad++;
               $display("FAIL flush_extra got col=%0d want no beat", m_col);
            end else begin
               e = q.pop_front();
               if ({m_col, m_data, m_last} !== {e.col, e.data, e.last}) begin
                  bad++;
                  $display("FAIL flush_beat got col=%0d data=%h last=%b want col=%0d data=%h last=%b",
                           m_col, m_data, m_last, e.col, e.data, e.last);
               end
            end
         end
         @(negedge clk);
      end
      total++;
      if (beats != 2 || pulses != 1 || q.size() != 0) begin
         bad++;
         $display("FAIL flush_count got beats=%0d pulses=%0d left=%0d want 2/1/0", beats, pulses, q.size());
      end
   endtask

   task automatic test_flush_empty;
      logic [0:ROWS-1] pm;
      pm = 8'b1111_0111;
      @(negedge clk);
      flush = 1'b1; rvalidport = '0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         total++;
         if ({outread, m_valid, busy} !== 3'b000) begin
            bad++;
            $display("FAIL flush_empty got outread/valid/busy=%b want 000", {outread, m_valid, busy});
         end
      end
      flush = 1'b0; rvalidport = pm;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         total++;
         if ({outread, m_valid, busy} !== 3'b000) begin
            bad++;
            $display("FAIL partial_noflush got outread/valid/busy=%b want 000", {outread, m_valid, busy});
         end
      end
      rvalidport = '0;
   endtask

   task automatic test_back_to_back;
      beat_t e;
      @(negedge clk);
      load_row('1, 1'b0, 1'b1);
      m_ready = 1'b1;
      @(negedge clk);
      rvalidport = '0;
      for (int c = 0; c < ROWS; c++) begin
         total++;
         if (m_valid !== 1'b1 || q.size() == 0) begin
            bad++;
            $display("FAIL b2b_valid beat=%0d got valid=%b want 1", c, m_valid);
         end else begin
            e = q.pop_front();
            if ({m_col, m_data, m_last} !== {e.col, e.data, e.last}) begin
               bad++;
               $display("FAIL b2b_beat got col=%0d data=%h last=%b want col=%0d data=%h last=%b",
                        m_col, m_data, m_last, e.col, e.data, e.last);
            end
         end
         if (c == ROWS - 1) load_row('1, 1'b0, 1'b1);
         @(negedge clk);
      end
      total++;
      if ({outread, m_valid, busy} !== 3'b000) begin
         bad++;
         $display("FAIL b2b_gap got outread/valid/busy=%b want 000", {outread, m_valid, busy});
      end
      @(negedge clk);
      rvalidport = '0;
      total++;
      if (outread !== 1'b1 || m_valid !== 1'b1 || q.size() == 0) begin
         bad++;
         $display("FAIL b2b_recapture got outread=%b valid=%b want 1/1", outread, m_valid);
      end else begin
         e = q.pop_front();
         if ({m_col, m_data, m_last} !== {e.col, e.data, e.last}) begin
            bad++;
            $display("FAIL b2b_first got col=%0d data=%h want col=%0d data=%h", m_col, m_data, e.col, e.data);
         end
      end
      @(negedge clk);
      for (int c = 0; c < 12; c++) begin
         if (m_valid && q.size() != 0) begin
            e = q.pop_front();
            total++;
            if ({m_col, m_data, m_last} !== {e.col, e.data, e.last}) begin
               bad++;
               $display("FAIL b2b_drain got col=%0d data=%h want col=%0d data=%h", m_col, m_data, e.col, e.data);
            end
         end
         @(negedge clk);
      end
      total++;
      if (q.size() != 0 || m_valid !== 1'b0) begin
         bad++;
         $display("FAIL b2b_end got left=%0d valid=%b want 0/0", q.size(), m_valid);
      end
   endtask

   task automatic test_reset_mid_row;
      beat_t e;
      @(negedge clk);
      load_row('1, 1'b0, 1'b0);
      m_ready = 1'b1;
      @(negedge clk);
      rvalidport = '0;
      for (int c = 0; c < 3; c++) begin
         if (q.size() != 0) e = q.pop_front();
         total++;
         if (m_valid !== 1'b1 || m_col !== e.col || m_data !== e.data) begin
            bad++;
            $display("FAIL rst_pre got valid=%b col=%0d data=%h want 1/%0d/%h", m_valid, m_col, m_data, e.col, e.data);
         end
         @(negedge clk);
      end
      #2 rstn = 1'b0;
      #1;
      total++;
      if ({outread, m_valid, m_last, busy} !== 4'b0000 || m_data !== '0 || m_col !== '0) begin
         bad++;
         $display("FAIL rst_async got ctrl=%b data=%h col=%0d want 0000/0/0",
                  {outread, m_valid, m_last, busy}, m_data, m_col);
      end
      q.delete();
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      rvalidport = 8'b0111_1111;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         total++;
         if ({outread, m_valid, busy} !== 3'b000) begin
            bad++;
            $display("FAIL rst_after got outread/valid/busy=%b want 000", {outread, m_valid, busy});
         end
      end
      load_row('1, 1'b0, 1'b1);
      @(negedge clk);
      rvalidport = '0;
      total++;
      if (outread !== 1'b1 || m_valid !== 1'b1 || q.size() == 0) begin
         bad++;
         $display("FAIL rst_recapture got outread=%b valid=%b want 1/1", outread, m_valid);
      end else begin
         e = q.pop_front();
         if ({m_col, m_data} !== {e.col, e.data}) begin
            bad++;
            $display("FAIL rst_first got col=%0d data=%h want col=%0d data=%h", m_col, m_data, e.col, e.data);
         end
      end
      repeat (ROWS + 2) @(negedge clk);
      q.delete();
   endtask

`ifdef SA_DRAIN_ROWCNT_EN
   task automatic test_rowcount;
      @(negedge clk);
      force dut.row_count = 16'hFFFF;
      @(negedge clk);
      release dut.row_count;
      load_row('1, 1'b0, 1'b0);
      m_ready = 1'b1;
      @(negedge clk);
      rvalidport = '0;
      repeat (ROWS + 2) @(negedge clk);
      load_row(8'b0100_0000, 1'b1, 1'b0);
      @(negedge clk);
      rvalidport = '0; flush = 1'b0;
      repeat (4) @(negedge clk);
      q.delete();
      total++;
      if (row_count !== 16'd1) begin
         bad++;
         $display("FAIL rowcnt_wrap got=%0d want=1", row_count);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_full_row();
      test_backpressure();
      test_flush_partial();
      test_flush_empty();
      test_back_to_back();
      test_reset_mid_row();
`ifdef SA_DRAIN_ROWCNT_EN
      test_rowcount();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sa_result_drain.md
# sa_result_drain

Result reader for the systolic array core's output side. Watches the core's per-column result ports and valid bits, snapshots one complete output row, and acknowledges it with a one-cycle `outread` pulse. It then serializes the row onto a single ready/valid stream, one column per beat, in ascending column order. A `flush` input drains partial rows at end of computation.

## Interface
Parameters:
- `ROWS`, default 8: array columns/rows; must be ≥ 2.
- `OUTWIDTH`, default 32: result width.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rstn`  in  1  reset; asynchronous and active-low.
- `routport`  in  `[OUTWIDTH-1:0]` x `[0:ROWS-1]`  per-column result from the core.
- `rvalidport`  in  `[0:ROWS-1]`  per-column result valid from the core.
- `outread`  out  1  one-cycle pulse; all buffered results are consumed; drives the core's `outread`.
- `flush`  in  1  drain a partial row (IDLE only).
- `m_data`  out  OUTWIDTH  stream data.
- `m_col`  out  `$clog2(ROWS)`  column index of the current beat.
- `m_last`  out  1  last beat of the current row.
- `m_valid`  out  1  stream valid.
- `m_ready`  in  1  stream ready from downstream.
- `busy`  out  1  high in SEND.

## Operation
- FSM states: IDLE and SEND.
- IDLE: capture when `rvalidport` is all ones. Capture also when `flush`=1 and `rvalidport` is nonzero.
  - On capture, latch all `routport` words and the valid mask into the snapshot.
  - Set `outread`=1 for exactly one cycle.
  - Go to SEND.
- IDLE with `flush`=1 and `rvalidport`=0: no action, no pulse.
- SEND: present the lowest set bit of the remaining mask.
  - `m_data` = snapshot word for that column; `m_col` = that column index.
  - `m_last`=1 when it is the only remaining bit.
  - On `m_valid && m_ready`, clear the bit. Invalid columns are skipped with no bubble cycle.
  - After the `m_last` handshake, go to IDLE.
- `flush` during SEND is ignored, not remembered. `rvalidport` changes during SEND are ignored.
- Results pass through unmodified; no arithmetic on data.

## Timing
- Reset values: `outread`=0, `m_valid`=0, `m_data`=0, `m_col`=0, `m_last`=0, `busy`=0. Snapshot and mask are cleared.
- Capture at edge E. In the cycle after E:
  - `outread`=1 and `m_valid`=1, with the first column presented.
  - `busy`=1.
  - `outread`=0 from the cycle after that.
- With `m_ready` held high: one beat per cycle, and a full row takes ROWS cycles.
- The earliest next capture is at the edge ending the `m_last` handshake cycle plus one. So the minimum row period is ROWS+1 cycles.
- Because ROWS ≥ 2, the core's valid bits have dropped before IDLE re-samples them, so one row is never captured twice.
- AXI-style hold rule: while `m_valid && !m_ready`, `m_data`, `m_col` and `m_last` stay stable. `m_valid` never drops without a handshake.
- `m_valid` is independent of `m_ready` (no combinational path from `m_ready` to `m_valid`).
- Reset asserted mid-SEND: all outputs go immediately to reset values. The snapshot is discarded. No further `outread` is issued.

## Configuration
- `SA_DRAIN_ROWCNT_EN` defined: adds output port `row_count`, 16 bits, reset value 0.
  - Increments by 1 at every capture edge, including flush captures.
  - Wraps from 65535 to 0.
- Not defined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Full row, ROWS=8, `rvalidport`=8'hFF, `routport[i]`=i*16, `m_ready`=1.
  - `outread` is high for exactly 1 cycle.
  - Beats `m_col` 0..7 carry data 0,16,…,112 on 8 consecutive cycles; `m_last` is set only on col 7.
  - `busy` drops after col 7.
- Backpressure: full row with `m_ready` toggling 1,0,0,1,…
  - Data and col stay stable while stalled.
  - All 8 beats are delivered in order; exactly one `outread` pulse.
- Flush, partial row: `rvalidport`=8'b0010_0100 (cols 2 and 5 valid), `flush`=1.
  - Two beats: col 2, then col 5 with `m_last`=1.
  - One `outread` pulse.
- Flush on empty: `flush`=1, `rvalidport`=0 → no `outread`, `m_valid` stays 0, `busy` stays 0.
- Reset mid-row: assert `rstn`=0 after beat 3 of a full row.
  - All outputs go to 0 asynchronously.
  - After release, the block re-captures only on a new all-valid row.
- With `SA_DRAIN_ROWCNT_EN`: preload the counter path with 65535 captures plus 2 more → `row_count` reads 1.
